serial_rx_frontend: RTL and testbench

Oversampling serial line receiver that sits directly upstream of the SIPO FIFO. It synchronises a raw asynchronous serial line, detects start/stop-framed characters, majority-votes each bit at its centre, and emits one `bit_valid`/`bit_data` strobe per data bit. These strobes drive the SIPO's `en`/`sin` inputs, and the block reports per-frame completion and error status.

---
 rtl/serial_rx_frontend_if.sv | 9 +
 rtl/serial_rx_frontend.sv | 182 ++++++++++++++++++
 tb/tb_serial_rx_frontend.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_frontend_if.sv
// rtl/serial_rx_frontend_if.sv - recovered-bit strobe channel from the receiver to the SIPO write side
interface serial_rx_frontend_if;
    logic bit_valid;
    logic bit_data;
    logic bit_ready;

    modport master (output bit_valid, output bit_data, input bit_ready);
    modport slave  (input bit_valid, input bit_data, output bit_ready);
endinterface

// File: rtl/serial_rx_frontend.sv
// rtl/serial_rx_frontend.sv - oversampling start/stop serial receiver emitting one strobe per data bit
// Optional even-parity bit is built when SERIAL_RX_PARITY_EN is defined.
module serial_rx_frontend #(
    parameter int OVERSAMPLE = 8,
    parameter int FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_rxd,
    input  logic                  i_overrun_clr,
    serial_rx_frontend_if.master  bit_if,
    output logic                  o_frame_done,
    output logic                  o_framing_err,
    output logic                  o_parity_err,
    output logic                  o_overrun,
    output logic                  o_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [2:0]      r_hist;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic            r_bit_valid;
    logic            r_bit_data;
    logic            r_frame_done;
    logic            r_framing_err;
    logic            r_overrun;
    logic            r_busy;
`ifdef SERIAL_RX_PARITY_EN
    logic            r_par;
    logic            r_parity_err;
`endif

    logic w_vote;
    logic w_mid;
    logic w_end;
    logic w_last_bit;

    assign w_vote     = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
    assign w_mid      = (r_cnt == CW'(OVERSAMPLE / 2 - 1));
    assign w_end      = (r_cnt == CW'(OVERSAMPLE - 1));
    assign w_last_bit = (r_idx == IW'(FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_hist        <= 3'b111;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_bit_valid   <= 1'b0;
            r_bit_data    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par         <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_sync1       <= i_rxd;
            r_sync2       <= r_sync1;
            r_hist        <= {r_hist[1:0], r_sync2};
            r_bit_valid   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_framing_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_parity_err  <= 1'b0;
`endif
            r_busy        <= (r_state != S_IDLE);
            r_cnt         <= r_cnt + 1'b1;

            // A new overrun in the same cycle as a clear must survive.
            if (r_bit_valid && !bit_if.bit_ready) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
`ifdef SERIAL_RX_PARITY_EN
                    r_par <= 1'b0;
`endif
                    if (!r_hist[0]) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_mid) begin
                        r_cnt   <= '0;
                        r_state <= w_vote ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_end) begin
                        r_cnt       <= '0;
                        r_bit_valid <= 1'b1;
                        r_bit_data  <= w_vote;
`ifdef SERIAL_RX_PARITY_EN
                        r_par       <= r_par ^ w_vote;
`endif
                        if (w_last_bit) begin
                            r_idx   <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                S_PARITY: begin
                    if (w_end) begin
                        r_cnt        <= '0;
                        r_parity_err <= (w_vote != r_par);
                        r_state      <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_end) begin
                        r_cnt <= '0;
                        if (w_vote) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_framing_err <= 1'b1;
                            r_state       <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // Held here through a line break until the line returns high.
                    r_cnt <= '0;
                    if (r_hist[0]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bit_if.bit_valid = r_bit_valid;
    assign bit_if.bit_data  = r_bit_data;
    assign o_frame_done     = r_frame_done;
    assign o_framing_err    = r_framing_err;
    assign o_overrun        = r_overrun;
    assign o_busy           = r_busy;
`ifdef SERIAL_RX_PARITY_EN
    assign o_parity_err     = r_parity_err;
`else
    assign o_parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_frontend.sv
// tb/tb_serial_rx_frontend.sv - table-driven and scoreboard bench for serial_rx_frontend
module tb_serial_rx_frontend;
    localparam int OS = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rxd = 1'b1;
    logic ovr_clr = 1'b0;
    logic fd, fe, pe, ovr, busy;

    serial_rx_frontend_if bif ();

    serial_rx_frontend #(.OVERSAMPLE(OS), .FRAME_BITS(8)) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_rxd         (rxd),
        .i_overrun_clr (ovr_clr),
        .bit_if        (bif),
        .o_frame_done  (fd),
        .o_framing_err (fe),
        .o_parity_err  (pe),
        .o_overrun     (ovr),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_fd = 0, n_fe = 0, n_pe = 0, n_bv = 0;
    int cyc = 0;
    int last_bv = -100;
    int ovr_arm = 0;
    int arm_cnt = 0;
    int rs = 0;
    bit chk_set_win = 1'b0;
    logic exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer and bit_ready / overrun-window driver.
    initial begin
        logic b;
        bif.bit_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (fd) n_fd++;
            if (fe) n_fe++;
            if (pe) n_pe++;
            if (chk_set_win) begin
                check("ovr_set_wins_over_clr", int'(ovr), 1);
                chk_set_win = 1'b0;
            end
            if (ovr_arm == 0) begin
                arm_cnt = 0;
                rs = 0;
            end else if (rs == 1 && !bif.bit_valid) begin
                bif.bit_ready = 1'b0;
                rs = 2;
            end else if (rs == 3 && !bif.bit_valid) begin
                bif.bit_ready = 1'b1;
                rs = 0;
            end
            if (bif.bit_valid) begin
                n_bv++;
                if (exp_q.size() == 0) begin
                    check("unexpected_bit_valid", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("bit_data", int'(bif.bit_data), int'(b));
                end
                if (cyc - last_bv <= 2 * OS) check("bit_valid_spacing", cyc - last_bv, OS);
                last_bv = cyc;
                if (ovr_arm != 0) begin
                    arm_cnt++;
                    if (arm_cnt == 3) rs = 1;
                    if (arm_cnt == 4 && rs == 2) begin
                        rs = 3;
                        if (ovr_arm == 1) check("ovr_before_4th", int'(ovr), 0);
                        else chk_set_win = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        tick(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_len,
                              input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            send_bit(d[i]);
        end
`ifdef SERIAL_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) check("par_flip_without_parity", 1, 0);
`endif
        for (int i = 0; i < stop_len; i++) send_bit(stop_lvl);
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_lvl;
        int         exp_fd;
        int         exp_fe;
    } vec_t;

    vec_t vt[6];
    int fd0, fe0, pe0, bv0;
    int busy_hi;
    bit saw_busy;

    initial begin
        vt[0] = '{8'hA5, 1'b1, 1, 0};
        vt[1] = '{8'h00, 1'b1, 1, 0};
        vt[2] = '{8'hFF, 1'b1, 1, 0};
        vt[3] = '{8'h3C, 1'b0, 0, 1};
        vt[4] = '{8'h55, 1'b1, 1, 0};
        vt[5] = '{8'h6E, 1'b1, 1, 0};

        tick(5);
        check("rst_bit_valid", int'(bif.bit_valid), 0);
        check("rst_bit_data", int'(bif.bit_data), 0);
        check("rst_frame_done", int'(fd), 0);
        check("rst_framing_err", int'(fe), 0);
        check("rst_parity_err", int'(pe), 0);
        check("rst_overrun", int'(ovr), 0);
        check("rst_busy", int'(busy), 0);
        rstn = 1'b1;
        tick(10);

        for (int v = 0; v < 6; v++) begin
            fd0 = n_fd; fe0 = n_fe; pe0 = n_pe; bv0 = n_bv;
            send_frame(vt[v].data, vt[v].stop_lvl, 1, 1'b0);
            tick(24);
            check("vec_frame_done", n_fd - fd0, vt[v].exp_fd);
            check("vec_framing_err", n_fe - fe0, vt[v].exp_fe);
            check("vec_parity_err", n_pe - pe0, 0);
            check("vec_bit_count", n_bv - bv0, 8);
            check("vec_queue_empty", exp_q.size(), 0);
            check("vec_busy_idle", int'(busy), 0);
        end

        // Back-to-back frames with no idle gap.
        fd0 = n_fd; bv0 = n_bv;
        send_frame(8'h5A, 1'b1, 1, 1'b0);
        send_frame(8'hC3, 1'b1, 1, 1'b0);
        tick(24);
        check("b2b_frame_done", n_fd - fd0, 2);
        check("b2b_bit_count", n_bv - bv0, 16);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Short glitch: false start, no bits.
        bv0 = n_bv; fd0 = n_fd; fe0 = n_fe;
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        busy_hi = 0;
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) begin
                saw_busy = 1'b1;
                busy_hi++;
            end
        end
        check("glitch_saw_busy", int'(saw_busy), 1);
        check("glitch_busy_short", int'(busy_hi <= 6), 1);
        check("glitch_busy_low", int'(busy), 0);
        check("glitch_no_bits", n_bv - bv0, 0);
        check("glitch_no_frame", (n_fd - fd0) + (n_fe - fe0), 0);

        // Stop bit held low for three bit times, then recovery.
        fd0 = n_fd; fe0 = n_fe;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(1'(8'h3C >> i));
            send_bit(1'(8'h3C >> i));
        end
`ifdef SERIAL_RX_PARITY_EN
        send_bit(^8'h3C);
`endif
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        check("brk_framing_err", n_fe - fe0, 1);
        check("brk_busy_in_wait", int'(busy), 1);
        rxd = 1'b1;
        tick(8);
        check("brk_busy_released", int'(busy), 0);
        send_frame(8'h01, 1'b1, 1, 1'b0);
        tick(24);
        check("brk_next_frame_done", n_fd - fd0, 1);
        check("brk_fe_single", n_fe - fe0, 1);
        check("brk_queue_empty", exp_q.size(), 0);

        // Overrun on the 4th strobe, then clear.
        ovr_arm = 1;
        fd0 = n_fd; bv0 = n_bv;
        send_frame(8'h81, 1'b1, 1, 1'b0);
        tick(24);
        ovr_arm = 0;
        check("ovr_all_bits", n_bv - bv0, 8);
        check("ovr_frame_done", n_fd - fd0, 1);
        check("ovr_sticky", int'(ovr), 1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check("ovr_cleared", int'(ovr), 0);
        tick(2);
        ovr_arm = 2;
        ovr_clr = 1'b1;
        send_frame(8'h81, 1'b1, 1, 1'b0);
        tick(24);
        ovr_arm = 0;
        ovr_clr = 1'b0;
        tick(1);
        check("ovr_clr_held_after", int'(ovr), 0);
        check("ovr_queue_empty", exp_q.size(), 0);

        // Reset during data bit 4 of 0xFF.
        fd0 = n_fd; fe0 = n_fe;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(1'b1);
            send_bit(1'b1);
        end
        tick(4);
        rstn = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_bit_valid", int'(bif.bit_valid), 0);
        rstn = 1'b1;
        tick(80);
        check("mid_rst_no_done", n_fd - fd0, 0);
        check("mid_rst_no_ferr", n_fe - fe0, 0);
        check("mid_rst_queue", exp_q.size(), 0);
        send_frame(8'h55, 1'b1, 1, 1'b0);
        tick(24);
        check("post_rst_frame_done", n_fd - fd0, 1);
        check("post_rst_queue", exp_q.size(), 0);

`ifdef SERIAL_RX_PARITY_EN
        fd0 = n_fd; pe0 = n_pe;
        send_frame(8'h07, 1'b1, 1, 1'b1);
        tick(24);
        check("par_bad_parity_err", n_pe - pe0, 1);
        check("par_bad_frame_done", n_fd - fd0, 1);
        fd0 = n_fd; pe0 = n_pe;
        send_frame(8'h07, 1'b1, 1, 1'b0);
        tick(24);
        check("par_good_parity_err", n_pe - pe0, 0);
        check("par_good_frame_done", n_fd - fd0, 1);
`else
        check("no_parity_pulses", n_pe, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
